// File: rtl/tlb_pkg.sv
// tlb_pkg: shared types and helpers for the multi-port joint TLB.
//   tlb_entry_t  : one TLB slot image, MSB->LSB vpn2, asid, g, even page, odd page
//   tlb_result_t : translation result returned by a lookup channel
//   entry_result : picks the even/odd page of a matched entry and forms paddr
package tlb_pkg;

  localparam int         ENTRY_W    = 78;
  localparam logic [2:0] C_UNCACHED = 3'd2;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic        miss;
    logic        v;
    logic        d;
    logic        uncached;
    logic [31:0] paddr;
  } tlb_result_t;

  // Translation result for a hit: odd selects the odd page of the pair.
  function automatic tlb_result_t entry_result(input tlb_entry_t e, input logic odd,
                                               input logic [11:0] off);
    tlb_result_t r;
    r.miss = 1'b0;
    if (odd) begin
      r.v        = e.v1;
      r.d        = e.d1;
      r.uncached = (e.c1 == C_UNCACHED);
      r.paddr    = {e.pfn1, off};
    end else begin
      r.v        = e.v0;
      r.d        = e.d0;
      r.uncached = (e.c0 == C_UNCACHED);
      r.paddr    = {e.pfn0, off};
    end
    return r;
  endfunction

endpackage

// File: rtl/tlb_match.sv
// tlb_match: combinational associative match over the whole entry array with a
// lowest-index-wins priority encoder.
//   i_entries/i_present : array contents and per-slot valid bits
//   i_vaddr/i_asid      : address and ASID to match (g taken from the stored entry)
//   o_hit/o_index       : any match, and lowest matching slot (0 when no hit)
//   o_result            : translation of the selected slot, or a clean miss
module tlb_match
  import tlb_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  tlb_entry_t [NUM_ENTRIES-1:0] i_entries,
  input  logic [NUM_ENTRIES-1:0]       i_present,
  input  logic [31:0]                  i_vaddr,
  input  logic [7:0]                   i_asid,
  output logic                         o_hit,
  output logic [IDX_W-1:0]             o_index,
  output tlb_result_t                  o_result
);

  logic [NUM_ENTRIES-1:0] w_match;
  tlb_entry_t             w_sel;

  // Per-slot match vector.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_match[i] = i_present[i] && (i_entries[i].vpn2 == i_vaddr[31:13]) &&
                   (i_entries[i].g || (i_entries[i].asid == i_asid));
    end
  end

  // Scan from the top down so the lowest matching index is the last one kept.
  always_comb begin
    o_hit   = 1'b0;
    o_index = '0;
    w_sel   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        o_hit   = 1'b1;
        o_index = IDX_W'(i);
        w_sel   = i_entries[i];
      end else begin
        o_hit   = o_hit;
      end
    end
  end

  // A miss reports all-zero fields with miss set.
  always_comb begin
    o_result = '0;
    if (o_hit) begin
      o_result = entry_result(w_sel, i_vaddr[12], i_vaddr[11:0]);
    end else begin
      o_result.miss = 1'b1;
    end
  end

endmodule

// File: rtl/tlb_mport_chk.sv
// tlb_mport_chk: protocol checks on the CP0 command strobes.
//   A read-back or probe must never share a cycle with a tlbwi/tlbwr.
module tlb_mport_chk (
  input logic i_clk,
  input logic i_rst,
  input logic i_tlbwi,
  input logic i_tlbwr,
  input logic i_tlbr,
  input logic i_tlbp
);

  a_no_read_with_write: assert property (@(posedge i_clk) disable iff (i_rst)
    !((i_tlbr || i_tlbp) && (i_tlbwi || i_tlbwr)));

endmodule

// File: rtl/tlb_mport.sv
// tlb_mport: NUM_ENTRIES-deep joint TLB shared by NUM_PORTS registered lookup
// channels, plus probe and read-back channels toward CP0.
//   i_req_valid/i_req_vaddr -> o_resp_* : one-cycle registered lookups per port
//   i_tlbwi/i_tlbwr/i_tlb_flush         : slot writes and whole-TLB invalidate
//   i_tlbr  -> o_read_valid, o_cp0_entry_out
//   i_tlbp  -> o_probe_valid, o_probe_miss, o_probe_index
//   o_random_index : Random counter, wraps to the top once at or below i_cp0_wired
module tlb_mport
  import tlb_pkg::*;
#(
  parameter int  NUM_ENTRIES = 16,
  parameter int  NUM_PORTS   = 2,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [7:0]                 i_curr_asid,
  input  logic [NUM_PORTS-1:0]       i_req_valid,
  input  logic [NUM_PORTS-1:0][31:0] i_req_vaddr,
  output logic [NUM_PORTS-1:0]       o_resp_valid,
  output logic [NUM_PORTS-1:0]       o_resp_miss,
  output logic [NUM_PORTS-1:0]       o_resp_v,
  output logic [NUM_PORTS-1:0]       o_resp_d,
  output logic [NUM_PORTS-1:0]       o_resp_uncached,
  output logic [NUM_PORTS-1:0][31:0] o_resp_paddr,
  input  logic                       i_tlbwi,
  input  logic                       i_tlbwr,
  input  logic                       i_tlbr,
  input  logic                       i_tlbp,
  input  logic                       i_tlb_flush,
  input  logic [IDX_W-1:0]           i_cp0_index,
  input  logic [IDX_W-1:0]           i_cp0_wired,
  input  logic [ENTRY_W-1:0]         i_cp0_entry_in,
  output logic [ENTRY_W-1:0]         o_cp0_entry_out,
  output logic                       o_read_valid,
  output logic                       o_probe_valid,
  output logic                       o_probe_miss,
  output logic [IDX_W-1:0]           o_probe_index,
  output logic [IDX_W-1:0]           o_random_index
);

  localparam logic [IDX_W-1:0] C_IDX_MAX = IDX_W'(NUM_ENTRIES - 1);

  tlb_entry_t [NUM_ENTRIES-1:0] r_entries;
  logic [NUM_ENTRIES-1:0]       r_present;
  logic [IDX_W-1:0]             r_random;
  tlb_entry_t                   w_entry_in;
  logic                         w_wr_en;
  logic [IDX_W-1:0]             w_wr_idx;

  assign w_entry_in = tlb_entry_t'(i_cp0_entry_in);

  // Write command decode: flush suppresses writes, tlbwr beats tlbwi.
  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_idx = i_cp0_index;
    if (i_tlb_flush) begin
      w_wr_en = 1'b0;
    end else if (i_tlbwr) begin
      w_wr_en  = 1'b1;
      w_wr_idx = r_random;
    end else if (i_tlbwi) begin
      w_wr_en = 1'b1;
    end else begin
      w_wr_en = 1'b0;
    end
  end

  // Present bits: flush clears all (field contents are kept), writes set one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_present <= '0;
    end else if (i_tlb_flush) begin
      r_present <= '0;
    end else if (w_wr_en) begin
      r_present[w_wr_idx] <= 1'b1;
    end
  end

  // Entry storage; qualified by present, so no reset needed.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_entries[w_wr_idx] <= w_entry_in;
    end
  end

  // Random counter; a wired value at or above the top pins it at the top.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_random <= C_IDX_MAX;
    end else if (r_random <= i_cp0_wired) begin
      r_random <= C_IDX_MAX;
    end else begin
      r_random <= r_random - IDX_W'(1);
    end
  end

  assign o_random_index = r_random;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic        w_hit;
    logic [IDX_W-1:0] w_idx;
    tlb_result_t w_raw;
    tlb_result_t w_res;
    tlb_result_t r_res;
    logic        r_valid;
    logic        w_unused_port;

    tlb_match #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_match (
      .i_entries (r_entries),
      .i_present (r_present),
      .i_vaddr   (i_req_vaddr[p]),
      .i_asid    (i_curr_asid),
      .o_hit     (w_hit),
      .o_index   (w_idx),
      .o_result  (w_raw)
    );

    // kseg0/kseg1 are unmapped: strip the segment bits, kseg1 is uncached.
    always_comb begin
      w_res = w_raw;
      if (i_req_vaddr[p][31:30] == 2'b10) begin
        w_res.miss     = 1'b0;
        w_res.v        = 1'b1;
        w_res.d        = 1'b1;
        w_res.uncached = i_req_vaddr[p][29];
        w_res.paddr    = {3'b000, i_req_vaddr[p][28:0]};
      end else begin
        w_res = w_raw;
      end
    end

    // Response register; fields update every cycle, valid qualifies them.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_valid <= 1'b0;
        r_res   <= '0;
      end else begin
        r_valid <= i_req_valid[p];
        r_res   <= w_res;
      end
    end

    assign o_resp_valid[p]    = r_valid;
    assign o_resp_miss[p]     = r_res.miss;
    assign o_resp_v[p]        = r_res.v;
    assign o_resp_d[p]        = r_res.d;
    assign o_resp_uncached[p] = r_res.uncached;
    assign o_resp_paddr[p]    = r_res.paddr;
    assign w_unused_port      = ^{w_hit, w_idx};
  end

  // Probe searches with the EntryHi image, not the current ASID.
  logic             w_probe_hit;
  logic [IDX_W-1:0] w_probe_idx;
  tlb_result_t      w_probe_res;
  logic             w_unused_probe;

  tlb_match #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_probe (
    .i_entries (r_entries),
    .i_present (r_present),
    .i_vaddr   ({w_entry_in.vpn2, 13'd0}),
    .i_asid    (w_entry_in.asid),
    .o_hit     (w_probe_hit),
    .o_index   (w_probe_idx),
    .o_result  (w_probe_res)
  );

  assign w_unused_probe = ^w_probe_res;

  tlb_entry_t r_entry_out;
  logic       r_read_valid;
  logic       r_probe_valid;
  logic       r_probe_miss;
  logic [IDX_W-1:0] r_probe_index;

  // Probe and read-back result registers; read-back data holds until next tlbr.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_entry_out   <= '0;
      r_read_valid  <= 1'b0;
      r_probe_valid <= 1'b0;
      r_probe_miss  <= 1'b0;
      r_probe_index <= '0;
    end else begin
      r_read_valid  <= i_tlbr;
      r_probe_valid <= i_tlbp;
      r_probe_miss  <= i_tlbp ? !w_probe_hit : 1'b0;
      r_probe_index <= i_tlbp ? w_probe_idx : IDX_W'(0);
      if (i_tlbr) begin
        r_entry_out <= r_entries[i_cp0_index];
      end
    end
  end

  assign o_cp0_entry_out = r_entry_out;
  assign o_read_valid    = r_read_valid;
  assign o_probe_valid   = r_probe_valid;
  assign o_probe_miss    = r_probe_miss;
  assign o_probe_index   = r_probe_index;

  tlb_mport_chk u_chk (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_tlbwi (i_tlbwi),
    .i_tlbwr (i_tlbwr),
    .i_tlbr  (i_tlbr),
    .i_tlbp  (i_tlbp)
  );

endmodule

// File: tb/tb_tlb_mport.sv
// tb_tlb_mport: directed self-checking bench for tlb_mport (16 entries, 2 ports).
module tb_tlb_mport;
  import tlb_pkg::*;

  localparam int NE = 16;
  localparam int NP = 2;
  localparam int IW = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          curr_asid;
  logic [NP-1:0]       req_valid;
  logic [NP-1:0][31:0] req_vaddr;
  logic [NP-1:0]       resp_valid, resp_miss, resp_v, resp_d, resp_uncached;
  logic [NP-1:0][31:0] resp_paddr;
  logic                tlbwi, tlbwr, tlbr, tlbp, tlb_flush;
  logic [IW-1:0]       cp0_index, cp0_wired;
  logic [ENTRY_W-1:0]  cp0_entry_in, cp0_entry_out;
  logic                read_valid, probe_valid, probe_miss;
  logic [IW-1:0]       probe_index, random_index;

  int vectors = 0;
  int miscompares = 0;

  tlb_mport #(.NUM_ENTRIES(NE), .NUM_PORTS(NP)) dut (
    .i_clk(clk), .i_rst(rst), .i_curr_asid(curr_asid),
    .i_req_valid(req_valid), .i_req_vaddr(req_vaddr),
    .o_resp_valid(resp_valid), .o_resp_miss(resp_miss), .o_resp_v(resp_v),
    .o_resp_d(resp_d), .o_resp_uncached(resp_uncached), .o_resp_paddr(resp_paddr),
    .i_tlbwi(tlbwi), .i_tlbwr(tlbwr), .i_tlbr(tlbr), .i_tlbp(tlbp),
    .i_tlb_flush(tlb_flush), .i_cp0_index(cp0_index), .i_cp0_wired(cp0_wired),
    .i_cp0_entry_in(cp0_entry_in), .o_cp0_entry_out(cp0_entry_out),
    .o_read_valid(read_valid), .o_probe_valid(probe_valid), .o_probe_miss(probe_miss),
    .o_probe_index(probe_index), .o_random_index(random_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  tlb_entry_t e3, e9, d2, d7, pe;

  initial begin
    e3 = '{vpn2:19'h00200, asid:8'd5, g:1'b0, pfn0:20'h12345, c0:3'd3, d0:1'b1, v0:1'b1,
           pfn1:20'h0ABCD, c1:3'd2, d1:1'b0, v1:1'b0};
    e9 = '{vpn2:19'h70001, asid:8'h11, g:1'b1, pfn0:20'hAAAAA, c0:3'd2, d0:1'b0, v0:1'b1,
           pfn1:20'h55555, c1:3'd3, d1:1'b1, v1:1'b1};
    d7 = '{vpn2:19'h12345, asid:8'd9, g:1'b0, pfn0:20'h77777, c0:3'd3, d0:1'b0, v0:1'b1,
           pfn1:20'h0, c1:3'd0, d1:1'b0, v1:1'b0};
    d2 = d7;
    d2.pfn0 = 20'h22222;

    rst = 1'b1; curr_asid = 8'd5; req_valid = '0; req_vaddr = '0;
    tlbwi = 1'b0; tlbwr = 1'b0; tlbr = 1'b0; tlbp = 1'b0; tlb_flush = 1'b0;
    cp0_index = '0; cp0_wired = 4'd4; cp0_entry_in = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_random", random_index, 96'd15);
    chk("rst_resp_valid", resp_valid, 96'd0);
    chk("rst_resp_miss", resp_miss, 96'd0);
    chk("rst_paddr", resp_paddr, 96'd0);
    chk("rst_read_probe", {read_valid, probe_valid, probe_miss, probe_index}, 96'd0);
    chk("rst_entry_out", cp0_entry_out, 96'd0);

    // Random sequence 15..4 then 15 with wired=4; tlbwr while random=9
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("random_seq", random_index, (k == 12) ? 96'd15 : 96'(15 - k));
      if (k == 6) begin
        cp0_entry_in = e9;
        tlbwr = 1'b1;
      end else begin
        tlbwr = 1'b0;
      end
    end

    // Read back slot 9
    cp0_index = 4'd9; tlbr = 1'b1;
    tick();
    tlbr = 1'b0;
    chk("tlbr_valid", read_valid, 96'd1);
    chk("tlbr_entry", cp0_entry_out, 96'(e9));
    tick();
    chk("tlbr_valid_drop", read_valid, 96'd0);
    chk("tlbr_hold", cp0_entry_out, 96'(e9));

    // Miss on empty mapping, port0 only
    req_valid = 2'b01; req_vaddr[0] = 32'h0040_0000;
    tick();
    req_valid = 2'b00;
    chk("miss_valid", resp_valid, 96'b01);
    chk("miss_flag", resp_miss[0], 96'd1);
    chk("miss_paddr", resp_paddr[0], 96'd0);

    // tlbwi slot 3 with same-cycle lookups on both ports: old contents seen
    cp0_index = 4'd3; cp0_entry_in = e3; tlbwi = 1'b1;
    req_valid = 2'b11; req_vaddr[0] = 32'h0040_0ABC; req_vaddr[1] = 32'h0040_1123;
    tick();
    tlbwi = 1'b0;
    chk("wr_same_cycle_valid", resp_valid, 96'b11);
    chk("wr_same_cycle_miss", resp_miss, 96'b11);
    tick();
    chk("hit_miss", resp_miss, 96'b00);
    chk("hit_paddr0", resp_paddr[0], 96'h1234_5ABC);
    chk("hit_paddr1", resp_paddr[1], 96'h0ABC_D123);
    chk("hit_v", resp_v, 96'b01);
    chk("hit_d", resp_d, 96'b01);
    chk("hit_uncached", resp_uncached, 96'b10);

    // Wrong ASID on a non-global entry
    curr_asid = 8'd6;
    tick();
    chk("asid_miss", resp_miss, 96'b11);
    chk("asid_miss_paddr", resp_paddr[0], 96'd0);
    chk("asid_miss_v", resp_v, 96'b00);
    curr_asid = 8'd5; req_valid = 2'b00;

    // Duplicate matches at slots 7 and 2
    cp0_index = 4'd7; cp0_entry_in = d7; tlbwi = 1'b1;
    tick();
    cp0_index = 4'd2; cp0_entry_in = d2;
    tick();
    tlbwi = 1'b0; tlbp = 1'b1; curr_asid = 8'd3;
    tick();
    chk("probe_dup", {probe_valid, probe_miss, probe_index}, {1'b1, 1'b0, 4'd2});
    pe = d2; pe.asid = 8'd8; cp0_entry_in = pe;
    tick();
    chk("probe_miss", {probe_valid, probe_miss, probe_index}, {1'b1, 1'b1, 4'd0});
    pe = e9; pe.asid = 8'h33; cp0_entry_in = pe;
    tick();
    tlbp = 1'b0;
    chk("probe_global", {probe_valid, probe_miss, probe_index}, {1'b1, 1'b0, 4'd9});
    curr_asid = 8'd9; req_valid = 2'b01; req_vaddr[0] = 32'h2468_A000;
    tick();
    chk("probe_drop", probe_valid, 96'd0);
    chk("dup_lookup", {resp_miss[0], resp_paddr[0]}, {1'b0, 32'h2222_2000});

    // Flush: earlier hits now miss
    curr_asid = 8'd5; req_valid = 2'b00; tlb_flush = 1'b1;
    tick();
    tlb_flush = 1'b0;
    req_valid = 2'b11; req_vaddr[0] = 32'h0040_0ABC; req_vaddr[1] = 32'h0040_1123;
    tick();
    chk("flush_miss", resp_miss, 96'b11);

    // kseg1 on port0, kseg0 on port1
    req_vaddr[0] = 32'hBFC0_0004; req_vaddr[1] = 32'h8000_1000;
    tick();
    chk("bypass_miss", resp_miss, 96'b00);
    chk("bypass_paddr0", resp_paddr[0], 96'h1FC0_0004);
    chk("bypass_paddr1", resp_paddr[1], 96'h0000_1000);
    chk("bypass_uncached", resp_uncached, 96'b01);
    chk("bypass_vd", {resp_v, resp_d}, 96'b1111);

    // Reset while a request is in flight
    req_valid = 2'b11;
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", resp_valid, 96'b00);
    tick();
    rst = 1'b0; req_valid = 2'b00;
    tick();
    chk("postrst_valid", resp_valid, 96'b00);
    chk("postrst_random", random_index, 96'd14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tlb_mport.md
# tlb_mport

Parametrised multi-port MIPS-style joint TLB: a single `NUM_ENTRIES`-deep entry array shared by `NUM_PORTS` registered lookup channels, plus a probe channel and a read-back channel toward CP0. It sits between the fetch/memory pipeline stages and CP0. It generalises the fixed inst/data/probe TLB to configurable depth and port count. It adds behaviour the fixed TLB lacks: one-cycle registered lookups, TLBR read-back, whole-TLB flush, kseg0/kseg1 bypass, and an internal Random counter honouring Wired.

## Interface
- `NUM_ENTRIES`, 16: entry count, power of two, 4..64; `IDX_W = $clog2(NUM_ENTRIES)`.
- `NUM_PORTS`, 2: lookup channels, 1..4.
- `clk` in 1: clock. `rst` in 1: asynchronous, active-high reset.
- `curr_asid` in 8: current ASID (EntryHi).
- `req_valid` in [NUM_PORTS]; `req_vaddr` in [NUM_PORTS][32]: lookup requests.
- `resp_valid`, `resp_miss`, `resp_v`, `resp_d`, `resp_uncached` out [NUM_PORTS]; `resp_paddr` out [NUM_PORTS][32].
- `tlbwi`, `tlbwr`, `tlbr`, `tlbp`, `tlb_flush` in 1: command strobes, single-cycle.
- `cp0_index` in IDX_W; `cp0_wired` in IDX_W.
- `cp0_entry_in` in ENTRY_W: EntryHi/Lo0/Lo1 image for writes and probe.
- `cp0_entry_out` out ENTRY_W; `read_valid` out 1: TLBR result.
- `probe_valid`, `probe_miss` out 1; `probe_index` out IDX_W.
- `random_index` out IDX_W: current Random value, exported to CP0.

## Operation
- Entry layout, MSB→LSB: vpn2[18:0], asid[7:0], g, pfn0[19:0], c0[2:0], d0, v0, pfn1[19:0], c1[2:0], d1, v1. ENTRY_W = 78. Each slot also holds a hidden `present` bit.
- Match condition: `present && vpn2 == vaddr[31:13] && (g || asid == curr_asid)`. With multiple hits, the lowest index wins.
- Page select: `vaddr[12]`. 0 selects the even page (pfn0/c0/d0/v0); 1 selects the odd page. `paddr = {pfn, vaddr[11:0]}`. `uncached = (c == 3'd2)`.
- Hit with v=0: miss=0, v=0, d and paddr still reported. The consumer raises TLB Invalid.
- No hit: miss=1, v=0, d=0, uncached=0, paddr=0.
- Bypass: `vaddr[31:30] == 2'b10` (kseg0/kseg1) never consults the array. Result: miss=0, v=1, d=1, paddr = `{3'b000, vaddr[28:0]}`, uncached = vaddr[29].
- tlbwi: writes `cp0_entry_in` to slot `cp0_index` and sets `present`.
- tlbwr: same, into slot `random_index`.
- tlbr: registers slot `cp0_index` (stored fields, `present` excluded) to `cp0_entry_out`. Holds until the next tlbr.
- tlbp: matches using `cp0_entry_in` vpn2 and asid, with g taken from the stored entry. `curr_asid` is ignored.
- tlb_flush: clears every `present` bit. Field contents are kept.
- Command priority: tlb_flush > tlbwr > tlbwi. tlbr/tlbp asserted together with a write is a protocol violation (assertion). tlbr and tlbp together is allowed.
- Random counter: decrements every cycle. When the current value ≤ `cp0_wired`, the next value is NUM_ENTRIES-1. If `cp0_wired` ≥ NUM_ENTRIES-1, it holds NUM_ENTRIES-1. A tlbwr does not alter the count sequence.

## Timing
- Lookup latency is 1 cycle. `resp_*` registered at edge t+1 from request in cycle t; `resp_valid[p] = req_valid[p]` delayed. Ports are fully pipelined, one request per cycle each.
- When `req_valid` is 0, response fields still update; only `resp_valid` qualifies them.
- Write/lookup in the same cycle t: the lookup sees pre-write contents. Requests in cycle t+1 see the new entry. There is no bypass.
- tlbp in cycle t: `probe_valid` pulses at t+1 with `probe_miss`/`probe_index`. Same-cycle write ordering is the same as for lookups.
- tlbr in cycle t: `read_valid` pulses at t+1 with `cp0_entry_out`.
- Reset values:
  - all `present` = 0, all `resp_*` = 0, `probe_*` = 0, `read_valid` = 0;
  - `cp0_entry_out` = 0, `random_index` = NUM_ENTRIES-1.
- Reset mid-operation: in-flight responses are discarded, with no valid pulse after deassertion.

## Structure
- `tlb_pkg` holds:
  - `tlb_entry_t` (packed struct, above order);
  - `ENTRY_W`;
  - a `tlb_result_t` struct (miss, v, d, uncached, paddr);
  - constant `C_UNCACHED = 3'd2`.
- Sub-module `tlb_match`: combinational match plus lowest-index priority encoder over the entry array. Outputs hit, index, and selected result. Instantiated NUM_PORTS+1 times (lookups and probe).
- `tlb_mport` owns the array, the `present` bits, the command logic, the Random counter and the output registers.

## Test plan
- Reset, then port0 lookup 0x0040_0000 → at t+1 resp_valid=1, miss=1; random_index=15.
- tlbwi index 3: vpn2=0x00200, asid=5, g=0, pfn0=0x12345, c0=3, d0=v0=1. Then lookup 0x0040_0ABC with asid 5 → paddr 0x12345ABC, v=1, d=1, uncached=0. Same lookup with asid 6 → miss=1.
- Same-cycle tlbwi and lookup on both ports → miss both; next cycle → hit both.
- wired=4: random_index sequence 15,14,…,4,15. tlbwr in a cycle with random=9 → tlbr index 9 returns the written entry.
- Duplicate matching entries at slots 2 and 7, tlbp → probe_index=2, probe_miss=0.
- tlb_flush → prior hit misses. Lookup 0xBFC0_0004 → paddr 0x1FC0_0004, uncached=1, miss=0. Lookup 0x8000_1000 → uncached=0.
